// File: rtl/pll_reset_sequencer_pkg.sv
// Shared state encodings and default timing constants for the PLL reset sequencer,
// so board tops and benches agree on the same values.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_STABLE    = 1024;
  localparam int DEF_LOCK_TIMEOUT   = 1048576;
  localparam int DEF_RST_HOLD       = 256;
  localparam int DEF_CW             = 21;

  // Event counters stick at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level (PLL lock).
// Data flops carry no reset so the chain stays a plain shift register.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    sync_reg <= {sync_reg[STAGES-2:0], d};
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, waits for a stable lock, then releases the downstream reset.
// Re-sequences on lock loss, lock timeout or a software request.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int RST_HOLD       = DEF_RST_HOLD,
  parameter int CW             = DEF_CW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       force_reset,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_lost_cnt
);

  seq_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, tcnt_reg, scnt_reg;
  logic          lk, retry_hit, lost_hit;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .d   (pll_lock),
    .q   (lk)
  );

  // A lock drop outranks force_reset so a simultaneous pair is counted once.
  always_comb begin
    state_next = state_reg;
    retry_hit  = 1'b0;
    lost_hit   = 1'b0;
    case (state_reg)
      PLL_RST: begin
        if (cnt_reg == CW'(PLL_RST_CYCLES - 1)) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (force_reset) begin
          state_next = PLL_RST;
        end else if (lk && scnt_reg == CW'(LOCK_STABLE - 1)) begin
          state_next = HOLD;
        end else if (tcnt_reg == CW'(LOCK_TIMEOUT - 1)) begin
          state_next = PLL_RST;
          retry_hit  = 1'b1;
        end
      end
      HOLD: begin
        if (!lk) begin
          state_next = PLL_RST;
          lost_hit   = 1'b1;
        end else if (force_reset) begin
          state_next = PLL_RST;
        end else if (cnt_reg == CW'(RST_HOLD - 1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!lk) begin
          state_next = PLL_RST;
          lost_hit   = 1'b1;
        end else if (force_reset) begin
          state_next = PLL_RST;
        end
      end
      default: state_next = PLL_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= PLL_RST;
      cnt_reg       <= '0;
      tcnt_reg      <= '0;
      scnt_reg      <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      retry_cnt     <= 8'd0;
      lock_lost_cnt <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        cnt_reg  <= '0;
        tcnt_reg <= '0;
        scnt_reg <= '0;
      end else begin
        if (state_reg == PLL_RST || state_reg == HOLD) cnt_reg <= cnt_reg + CW'(1);
        if (state_reg == WAIT_LOCK) begin
          tcnt_reg <= tcnt_reg + CW'(1);
          scnt_reg <= lk ? scnt_reg + CW'(1) : '0;
        end
      end
      pll_rst <= (state_next == PLL_RST);
      sys_rst <= (state_next != RUN);
      ready   <= (state_next == RUN);
      if (retry_hit) retry_cnt <= sat_inc8(retry_cnt);
      if (lost_hit)  lock_lost_cnt <= sat_inc8(lock_lost_cnt);
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: a vector table for bring-up and lock loss, hand sequences
// for timeout, chatter, force and saturation, then randomized traffic vs. a model.
module tb_pll_reset_sequencer;

  localparam int SS  = 2;
  localparam int PRC = 4;
  localparam int LS  = 8;
  localparam int RH  = 6;
  localparam int LT  = 32;
  localparam int CW  = 21;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       force_reset = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [1:0] state;
  logic [7:0] retry_cnt, lock_lost_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES(SS), .PLL_RST_CYCLES(PRC), .LOCK_STABLE(LS),
    .LOCK_TIMEOUT(LT), .RST_HOLD(RH), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .force_reset(force_reset),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .state(state),
    .retry_cnt(retry_cnt), .lock_lost_cnt(lock_lost_cnt)
  );

  // Reference model: phase + entry timestamp + run length of consecutive lock samples.
  int m_state = 0, m_enter = 0, m_run = 0, m_retry = 0, m_lost = 0;
  int cyc = 0;
  bit lk_q[$];

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic go(input int s);
    m_state = s;
    m_enter = cyc + 1;
    m_run   = 0;
  endtask

  task automatic model_step(input bit pl, input bit f, input bit r);
    bit lk;
    int dwell;
    lk = lk_q.pop_front();
    lk_q.push_back(pl);
    dwell = cyc - m_enter;
    if (r) begin
      go(0);
      m_retry = 0;
      m_lost  = 0;
    end else begin
      case (m_state)
        0: if (dwell == PRC - 1) go(1);
        1: begin
          if (f) go(0);
          else if (lk && m_run == LS - 1) go(2);
          else if (dwell == LT - 1) begin go(0); m_retry = sat(m_retry); end
          else m_run = lk ? m_run + 1 : 0;
        end
        2: begin
          if (!lk) begin go(0); m_lost = sat(m_lost); end
          else if (f) go(0);
          else if (dwell == RH - 1) go(3);
        end
        default: begin
          if (!lk) begin go(0); m_lost = sat(m_lost); end
          else if (f) go(0);
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: capture the inputs the DUT will see, step the model, compare everything.
  task automatic cycle();
    bit pl, f, r;
    logic [20:0] exp_v;
    pl = pll_lock; f = force_reset; r = rst;
    @(posedge clk);
    #1;
    cyc++;
    model_step(pl, f, r);
    exp_v = {m_state[1:0], (m_state == 0), (m_state != 3), (m_state == 3),
             m_retry[7:0], m_lost[7:0]};
    check("model", {state, pll_rst, sys_rst, ready, retry_cnt, lock_lost_cnt}, exp_v);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    for (int i = 0; i < budget && state != s; i++) cycle();
    check("wait_state", state, s);
  endtask

  task automatic do_reset(input bit lock_v);
    rst = 1'b1; pll_lock = lock_v; force_reset = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    bit rst; bit lock; bit frc; int n;
    int st; bit prst; bit rdy; int retry; int lost;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, lost0;
    bit sys_low_seen, saw_hold;
    for (int i = 0; i < SS; i++) lk_q.push_back(1'b0);

    // Bring-up with lock from release cycle 6, then a 3-cycle lock drop in RUN.
    tbl[0]  = '{1, 0, 0, 3, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 6, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 9, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 2, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 5, 2, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 3, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 3, 3, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 2, 3, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, 4, 1, 0, 0, 0, 1};
    tbl[10] = '{0, 1, 0, 8, 2, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 6, 3, 0, 1, 0, 1};
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; pll_lock = tbl[i].lock; force_reset = tbl[i].frc;
      repeat (tbl[i].n) cycle();
      check($sformatf("tbl%0d_state", i), state, tbl[i].st);
      check($sformatf("tbl%0d_pll_rst", i), pll_rst, tbl[i].prst);
      check($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
      check($sformatf("tbl%0d_retry", i), retry_cnt, tbl[i].retry);
      check($sformatf("tbl%0d_lost", i), lock_lost_cnt, tbl[i].lost);
      $display("vector %0d: state=%0d pll_rst=%0b ready=%0b retry=%0d lost=%0d",
               i, state, pll_rst, ready, retry_cnt, lock_lost_cnt);
    end

    // Lock never asserts: 4 high / 32 low repeating, retry counts up.
    do_reset(1'b0);
    sys_low_seen = 1'b0;
    for (int rep = 0; rep < 3; rep++) begin
      hi = 1;
      for (int b = 0; b < 100 && pll_rst; b++) begin
        cycle(); if (pll_rst) hi++; if (!sys_rst) sys_low_seen = 1'b1;
      end
      lo = 1;
      for (int b = 0; b < 100 && !pll_rst; b++) begin
        cycle(); if (!pll_rst) lo++; if (!sys_rst) sys_low_seen = 1'b1;
      end
      check("timeout_hi_width", hi, PRC);
      check("timeout_lo_width", lo, LT);
      check("timeout_retry", retry_cnt, rep + 1);
      $display("timeout %0d: hi=%0d lo=%0d retry=%0d", rep, hi, lo, retry_cnt);
    end
    check("timeout_sys_rst_held", sys_low_seen, 1'b0);

    // Chattering lock never stays high long enough.
    do_reset(1'b0);
    saw_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pll_lock = (i % 6) != 5;
      cycle();
      if (state == 2'd2) saw_hold = 1'b1;
    end
    check("chatter_no_hold", saw_hold, 1'b0);
    check("chatter_retry", retry_cnt, 1);
    $display("chatter: retry=%0d hold_seen=%0b", retry_cnt, saw_hold);

    // Lock drop and force_reset land together; then force during PLL_RST.
    do_reset(1'b1);
    wait_state(2'd3, 100);
    lost0 = lock_lost_cnt;
    pll_lock = 1'b0;
    cycle(); cycle();
    check("drop_latency_still_run", state, 2'd3);
    force_reset = 1'b1;
    cycle();
    force_reset = 1'b0; pll_lock = 1'b1;
    check("drop_force_state", state, 2'd0);
    check("drop_force_lost_once", lock_lost_cnt, lost0 + 1);
    force_reset = 1'b1;
    cycle();
    force_reset = 1'b0;
    hi = 2;
    for (int b = 0; b < 50 && pll_rst; b++) begin
      cycle(); if (pll_rst) hi++;
    end
    check("force_in_pll_rst_width", hi, PRC);
    $display("force: lost=%0d pll_rst_width=%0d", lock_lost_cnt, hi);

    // Saturate lock_lost_cnt with 300 losses out of HOLD, then reset mid-HOLD.
    do_reset(1'b1);
    for (int i = 0; i < 300; i++) begin
      wait_state(2'd2, 100);
      pll_lock = 1'b0;
      cycle();
      pll_lock = 1'b1;
      wait_state(2'd0, 10);
    end
    check("lost_saturated", lock_lost_cnt, 255);
    $display("saturation: lost=%0d", lock_lost_cnt);
    wait_state(2'd2, 100);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midhold_state", state, 2'd0);
    check("midhold_pll_rst", pll_rst, 1'b1);
    check("midhold_sys_rst", sys_rst, 1'b1);
    check("midhold_ready", ready, 1'b0);
    check("midhold_lost", lock_lost_cnt, 0);
    $display("mid-HOLD reset: state=%0d pll_rst=%0b lost=%0d", state, pll_rst, lock_lost_cnt);

    // Randomized traffic compared against the model every cycle.
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
      force_reset = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0; force_reset = 1'b0;
    $display("random: state=%0d retry=%0d lost=%0d", state, retry_cnt, lock_lost_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
